sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width per bank in bits; multiple of 8.
REQ-002 SHALL have parameter BANK_ADDR_W, default 20, word address width per bank.
REQ-003 SHALL have parameter BANK_SEL_W, default 1; NUM_BANKS = 2**BANK_SEL_W.
REQ-004 SHALL have parameter READ_WAIT, default 4, cycles from strobe assertion to read sample; legal values 1..15.
REQ-005 SHALL have parameter WRITE_PULSE, default 2, cycles we_n is held low; legal values 1..15.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port req_valid, input, 1, request present.
REQ-009 SHALL have port req_ready, output, 1, controller can accept a request.
REQ-010 SHALL have port req_we, input, 1, 1=write, 0=read.
REQ-011 SHALL have port req_addr, input, BANK_SEL_W+BANK_ADDR_W, bank select in the MSBs, word address in the LSBs.
REQ-012 SHALL have port req_wdata, input, DATA_W, write data.
REQ-013 SHALL have port req_be, input, DATA_W/8, byte enables; 1 = write that byte.
REQ-014 SHALL have port rsp_valid, output, 1, one-cycle read-data-valid pulse.
REQ-015 SHALL have port rsp_rdata, output, DATA_W, registered read data.
REQ-016 SHALL have port wr_done, output, 1, one-cycle write-complete pulse.
REQ-017 SHALL have ports ram_addr (NUM_BANKS*BANK_ADDR_W), ram_data (inout, NUM_BANKS*DATA_W), ram_ce_n, ram_oe_n, ram_we_n (NUM_BANKS each) and ram_be_n (NUM_BANKS*DATA_W/8); bank k occupies slice k of each bus.

Function
REQ-018 SHALL implement the states IDLE, RD_WAIT, WR_SETUP, WR_PULSE and WR_HOLD; req_ready SHALL be 1 only in IDLE.
REQ-019 SHALL accept a request on a rising edge E0 with req_valid=1 in IDLE; it SHALL latch addr, wdata, be and we at E0, and SHALL ignore req_valid in all other states.
REQ-020 SHALL drive all SRAM strobes from registers; there SHALL be no negedge logic and no combinational path from req_* to ram_*.
REQ-021 Read: from E0, the selected bank SHALL have ce_n=0 and oe_n=0 with ram_addr valid; at E0+READ_WAIT it SHALL capture ram_data into rsp_rdata, pulse rsp_valid for the following cycle, deassert the strobes and return to IDLE.
REQ-022 Write: WR_SETUP (1 cycle) SHALL assert ce_n=0 with addr and data driven and we_n=1; WR_PULSE (WRITE_PULSE cycles) SHALL assert we_n=0; WR_HOLD (1 cycle) SHALL assert we_n=1 with data still driven; wr_done SHALL pulse in the IDLE cycle that follows.
REQ-023 SHALL keep ram_addr, ram_data and ram_be_n of the active bank stable for the whole access.
REQ-024 SHALL drive ram_data for a bank only in that bank's WR_SETUP/WR_PULSE/WR_HOLD and SHALL keep it high-Z otherwise.
REQ-025 Non-selected banks SHALL hold ce_n=oe_n=we_n=1 throughout.
REQ-026 SHALL accept a new request in the same cycle rsp_valid or wr_done is high (back-to-back, no idle gap).
REQ-027 rsp_rdata SHALL hold its value until the next read capture.
REQ-028 SHALL never assert oe_n=0 and we_n=0 together on any bank.

Reset
REQ-029 When rst_n=0 at an edge: state IDLE, req_ready=1 after release, rsp_valid=0, wr_done=0, rsp_rdata=0, all ce_n/oe_n/we_n/be_n=1, ram_data high-Z.
REQ-030 Reset during any access SHALL abort it at that edge with no rsp_valid or wr_done ever produced for it; we_n SHALL go high at that same edge.

Configuration
REQ-031 With macro SRAM_CTRL_BYTE_MASK_EN defined, ram_be_n of the active bank SHALL be ~req_be (latched) for writes and all-0 for reads.
REQ-032 Without SRAM_CTRL_BYTE_MASK_EN, req_be SHALL be ignored and ram_be_n of the active bank SHALL be all-0 for every access.

Verification
REQ-033 Read bank 0 at addr 0x012345, model returns 0xDEADBEEF, READ_WAIT=4 -> oe_n[0] low for 4 cycles, rsp_valid for 1 cycle after E4, rsp_rdata=0xDEADBEEF, ce_n[1] always 1.
REQ-034 Write bank 1 at addr 0x100010, data 0xA5A50F0F, be=4'b0011, WRITE_PULSE=2 -> we_n[1] low exactly 2 cycles, data stable from setup through hold, wr_done after E4, be_n[7:4]=4'b1100 (macro) / 4'b0000 (no macro).
REQ-035 Read issued in the same cycle a write's wr_done is high -> accepted, with no idle cycle and no oe/we overlap.
REQ-036 rst_n=0 during WR_PULSE -> we_n=1 at that edge, data high-Z, no wr_done, req_ready=1 after release.
REQ-037 req_valid held high throughout a read -> exactly one access performed; the second request is accepted only in IDLE.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-request controller for NUM_BANKS asynchronous SRAM banks.
// A request is accepted only in IDLE. Reads hold ce_n/oe_n low for READ_WAIT
// cycles and then capture the bus. Writes run setup, a WRITE_PULSE-cycle we_n
// pulse, and a hold cycle. Every SRAM pin comes straight from a flop.
// Optional feature macro: SRAM_CTRL_BYTE_MASK_EN. When it is defined, the
// latched req_be drives ram_be_n on writes. When it is not defined, every
// access enables all bytes.
module sram_ctrl #(
  parameter int DATA_W      = 32,
  parameter int BANK_ADDR_W = 20,
  parameter int BANK_SEL_W  = 1,
  parameter int READ_WAIT   = 4,
  parameter int WRITE_PULSE = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic                                      req_we,
  input  logic [BANK_SEL_W+BANK_ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]                         req_wdata,
  input  logic [DATA_W/8-1:0]                       req_be,
  output logic                                      rsp_valid,
  output logic [DATA_W-1:0]                         rsp_rdata,
  output logic                                      wr_done,
  output logic [(2**BANK_SEL_W)*BANK_ADDR_W-1:0]    ram_addr,
  inout  wire  [(2**BANK_SEL_W)*DATA_W-1:0]         ram_data,
  output logic [(2**BANK_SEL_W)-1:0]                ram_ce_n,
  output logic [(2**BANK_SEL_W)-1:0]                ram_oe_n,
  output logic [(2**BANK_SEL_W)-1:0]                ram_we_n,
  output logic [(2**BANK_SEL_W)*(DATA_W/8)-1:0]     ram_be_n
);

  localparam int NUM_BANKS = 2**BANK_SEL_W;
  localparam int BE_W      = DATA_W / 8;
  localparam int ADDR_W    = BANK_SEL_W + BANK_ADDR_W;
  // The counters are loaded with N-1 and count down to zero, so each phase lasts N cycles.
  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WP_LOAD = 4'(WRITE_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } state_t;

  state_t                          state_r, state_nx;
  logic [3:0]                      cnt_r, cnt_nx;
  logic                            we_r, we_nx;
  logic [BANK_SEL_W-1:0]           sel_r, sel_nx;
  logic [DATA_W-1:0]               wdata_r, wdata_nx;
  logic                            accept_s, capture_s;
  logic                            rsp_valid_nx, wr_done_nx;
  logic [DATA_W-1:0]               rdata_nx;
  logic [NUM_BANKS-1:0]            ce_n_nx, oe_n_nx, we_n_nx, drv_nx, drv_r;
  logic [NUM_BANKS*BE_W-1:0]       be_n_nx;
  logic [NUM_BANKS*BANK_ADDR_W-1:0] addr_nx;

`ifdef SRAM_CTRL_BYTE_MASK_EN
  logic [BE_W-1:0]                 be_r, be_nx;
`else
  // Byte enables play no part in this build.
  logic                            unused_be_s;
  assign unused_be_s = ^req_be;
`endif

  // Next-state logic and request latching. Requests are seen only in IDLE.
  always_comb begin
    state_nx     = state_r;
    cnt_nx       = cnt_r;
    we_nx        = we_r;
    sel_nx       = sel_r;
    wdata_nx     = wdata_r;
`ifdef SRAM_CTRL_BYTE_MASK_EN
    be_nx        = be_r;
`endif
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    rsp_valid_nx = 1'b0;
    wr_done_nx   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          we_nx    = req_we;
          sel_nx   = req_addr[ADDR_W-1 -: BANK_SEL_W];
          wdata_nx = req_wdata;
`ifdef SRAM_CTRL_BYTE_MASK_EN
          be_nx    = req_be;
`endif
          if (req_we) begin
            state_nx = WR_SETUP;
            cnt_nx   = 4'd0;
          end else begin
            state_nx = RD_WAIT;
            cnt_nx   = RD_LOAD;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_r == 4'd0) begin
          capture_s    = 1'b1;
          rsp_valid_nx = 1'b1;
          state_nx     = IDLE;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      WR_SETUP: begin
        state_nx = WR_PULSE;
        cnt_nx   = WP_LOAD;
      end
      WR_PULSE: begin
        if (cnt_r == 4'd0) begin
          state_nx = WR_HOLD;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      WR_HOLD: begin
        state_nx   = IDLE;
        wr_done_nx = 1'b1;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Next values of the registered SRAM pins, derived from the next state.
  always_comb begin
    ce_n_nx  = {NUM_BANKS{1'b1}};
    oe_n_nx  = {NUM_BANKS{1'b1}};
    we_n_nx  = {NUM_BANKS{1'b1}};
    drv_nx   = {NUM_BANKS{1'b0}};
    be_n_nx  = {(NUM_BANKS*BE_W){1'b1}};
    addr_nx  = ram_addr;
    rdata_nx = rsp_rdata;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if ((state_nx != IDLE) && (sel_nx == BANK_SEL_W'(k))) begin
        ce_n_nx[k] = 1'b0;
        oe_n_nx[k] = (state_nx == RD_WAIT) ? 1'b0 : 1'b1;
        we_n_nx[k] = (state_nx == WR_PULSE) ? 1'b0 : 1'b1;
        drv_nx[k]  = (state_nx != RD_WAIT) ? 1'b1 : 1'b0;
`ifdef SRAM_CTRL_BYTE_MASK_EN
        be_n_nx[k*BE_W +: BE_W] = we_nx ? ~be_nx : {BE_W{1'b0}};
`else
        be_n_nx[k*BE_W +: BE_W] = {BE_W{1'b0}};
`endif
      end else begin
        ce_n_nx[k] = 1'b1;
        oe_n_nx[k] = 1'b1;
        we_n_nx[k] = 1'b1;
        drv_nx[k]  = 1'b0;
        be_n_nx[k*BE_W +: BE_W] = {BE_W{1'b1}};
      end
      // Only the bank being accessed loads a new address. The other banks keep theirs.
      if (accept_s && (req_addr[ADDR_W-1 -: BANK_SEL_W] == BANK_SEL_W'(k))) begin
        addr_nx[k*BANK_ADDR_W +: BANK_ADDR_W] = req_addr[BANK_ADDR_W-1:0];
      end else begin
        addr_nx[k*BANK_ADDR_W +: BANK_ADDR_W] = ram_addr[k*BANK_ADDR_W +: BANK_ADDR_W];
      end
    end
    if (capture_s) begin
      rdata_nx = ram_data[int'(sel_r)*DATA_W +: DATA_W];
    end else begin
      rdata_nx = rsp_rdata;
    end
  end

  // State, latched request and all registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      we_r      <= 1'b0;
      sel_r     <= {BANK_SEL_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
`ifdef SRAM_CTRL_BYTE_MASK_EN
      be_r      <= {BE_W{1'b0}};
`endif
      drv_r     <= {NUM_BANKS{1'b0}};
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      wr_done   <= 1'b0;
      rsp_rdata <= {DATA_W{1'b0}};
      ram_addr  <= {(NUM_BANKS*BANK_ADDR_W){1'b0}};
      ram_ce_n  <= {NUM_BANKS{1'b1}};
      ram_oe_n  <= {NUM_BANKS{1'b1}};
      ram_we_n  <= {NUM_BANKS{1'b1}};
      ram_be_n  <= {(NUM_BANKS*BE_W){1'b1}};
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      we_r      <= we_nx;
      sel_r     <= sel_nx;
      wdata_r   <= wdata_nx;
`ifdef SRAM_CTRL_BYTE_MASK_EN
      be_r      <= be_nx;
`endif
      drv_r     <= drv_nx;
      req_ready <= (state_nx == IDLE);
      rsp_valid <= rsp_valid_nx;
      wr_done   <= wr_done_nx;
      rsp_rdata <= rdata_nx;
      ram_addr  <= addr_nx;
      ram_ce_n  <= ce_n_nx;
      ram_oe_n  <= oe_n_nx;
      ram_we_n  <= we_n_nx;
      ram_be_n  <= be_n_nx;
    end
  end

  // Each bank's data bus is driven only while that bank is in a write phase.
  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    assign ram_data[k*DATA_W +: DATA_W] = drv_r[k] ? wdata_r : {DATA_W{1'bz}};
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: a table of accesses is run through sram_ctrl, which is
// attached to a behavioural two-bank SRAM. The expected completions go into a
// queue, and a monitor checks each response and the pin timing every cycle.
module tb_sram_ctrl;
  localparam int DATA_W = 32, BANK_ADDR_W = 20, BANK_SEL_W = 1;
  localparam int READ_WAIT = 4, WRITE_PULSE = 2, NB = 2, BE_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, req_valid, req_ready, req_we, rsp_valid, wr_done;
  logic [20:0]       req_addr;
  logic [31:0]       req_wdata, rsp_rdata;
  logic [3:0]        req_be;
  logic [39:0]       ram_addr;
  wire  [63:0]       ram_data;
  logic [1:0]        ram_ce_n, ram_oe_n, ram_we_n;
  logic [7:0]        ram_be_n;

  sram_ctrl #(.DATA_W(DATA_W), .BANK_ADDR_W(BANK_ADDR_W), .BANK_SEL_W(BANK_SEL_W),
              .READ_WAIT(READ_WAIT), .WRITE_PULSE(WRITE_PULSE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_done(wr_done),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_be_n(ram_be_n));

  typedef struct {
    logic        we;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  typedef struct { logic we; logic [31:0] data; } exp_t;

`ifdef SRAM_CTRL_BYTE_MASK_EN
  localparam logic [31:0] EXP_V2 = 32'h11220F0F;
  localparam logic [31:0] EXP_V6 = 32'h01230000;
`else
  localparam logic [31:0] EXP_V2 = 32'hA5A50F0F;
  localparam logic [31:0] EXP_V6 = 32'h01234567;
`endif

  int   checks = 0, failures = 0;
  exp_t sb_q[$];
  vec_t stim;
  vec_t vecs[9];
  int   acc_count = 0;
  logic cur_we = 1'b0, cur_bank = 1'b0;
  logic [19:0] cur_word = 20'h0;
  logic [31:0] cur_wdata = 32'h0;
  logic [3:0]  cur_be = 4'h0;
  int   ce_run[NB], oe_run[NB], we_run[NB];
  logic prev_ce_low = 1'b0, prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Behavioural SRAM: the array is preloaded during reset and written while ce_n and we_n are low.
  logic [31:0] mem [NB][64];
  logic [NB-1:0] sram_oe;
  logic [31:0] sram_q [NB];
  always_comb begin
    for (int k = 0; k < NB; k++) begin
      sram_oe[k] = !ram_ce_n[k] && !ram_oe_n[k];
      sram_q[k]  = mem[k][ram_addr[k*BANK_ADDR_W +: 6]];
    end
  end
  for (genvar k = 0; k < NB; k++) begin : g_model
    assign ram_data[k*32 +: 32] = sram_oe[k] ? sram_q[k] : 32'bz;
  end
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NB; k++)
        for (int a = 0; a < 64; a++) mem[k][a] <= 32'h0;
      mem[0][5]  <= 32'hDEADBEEF;
      mem[0][2]  <= 32'h0BADF00D;
      mem[1][16] <= 32'h11223344;
    end else begin
      for (int k = 0; k < NB; k++)
        if (!ram_ce_n[k] && !ram_we_n[k])
          for (int b = 0; b < BE_W; b++)
            if (!ram_be_n[k*BE_W+b])
              mem[k][ram_addr[k*BANK_ADDR_W +: 6]][b*8 +: 8] <= ram_data[k*32+b*8 +: 8];
    end
  end

  // On every accepted request, queue its expected result and record the access now in flight.
  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      sb_q.push_back('{req_we, stim.exp});
      acc_count <= acc_count + 1;
      cur_we    <= req_we;
      cur_bank  <= req_addr[20];
      cur_word  <= req_addr[19:0];
      cur_wdata <= req_wdata;
      cur_be    <= req_be;
    end
  end

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_underflow got=done_pulse want=none");
    end else begin
      e = sb_q.pop_front();
      chk("done_kind", {63'd0, wr_done}, {63'd0, e.we});
      if (rsp_valid) chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.data});
    end
  endtask

  // Pin and response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NB; k++) begin
        ce_run[k] <= 0; oe_run[k] <= 0; we_run[k] <= 0;
      end
      sb_q.delete();
      prev_ce_low <= 1'b0;
      prev_done   <= 1'b0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        chk("no_oe_we_overlap", {63'd0, ram_oe_n[k] | ram_we_n[k]}, 64'd1);
        if (!ram_ce_n[k]) begin
          chk("active_bank", k, {63'd0, cur_bank});
          chk("ram_addr", {44'd0, ram_addr[k*20 +: 20]}, {44'd0, cur_word});
`ifdef SRAM_CTRL_BYTE_MASK_EN
          chk("be_n", {60'd0, ram_be_n[k*4 +: 4]}, {60'd0, cur_we ? ~cur_be : 4'h0});
`else
          chk("be_n", {60'd0, ram_be_n[k*4 +: 4]}, 64'd0);
`endif
          chk("oe_n_kind", {63'd0, ram_oe_n[k]}, {63'd0, cur_we});
          if (!ram_we_n[k]) chk("wdata", {32'd0, ram_data[k*32 +: 32]}, {32'd0, cur_wdata});
          ce_run[k] <= ce_run[k] + 1;
        end else begin
          chk("idle_strobes", {58'd0, ram_oe_n[k], ram_we_n[k], ram_be_n[k*4 +: 4]}, 64'h3F);
          if (ce_run[k] != 0) chk("ce_len", ce_run[k], cur_we ? WRITE_PULSE + 2 : READ_WAIT);
          ce_run[k] <= 0;
        end
        if (!ram_oe_n[k]) oe_run[k] <= oe_run[k] + 1;
        else begin
          if (oe_run[k] != 0) chk("oe_len", oe_run[k], READ_WAIT);
          oe_run[k] <= 0;
        end
        if (!ram_we_n[k]) we_run[k] <= we_run[k] + 1;
        else begin
          if (we_run[k] != 0) chk("we_len", we_run[k], WRITE_PULSE);
          we_run[k] <= 0;
        end
      end
      if (rsp_valid || wr_done) begin
        chk("done_exclusive", {63'd0, rsp_valid & wr_done}, 64'd0);
        chk("done_after_access", {63'd0, prev_ce_low}, 64'd1);
        chk("done_strobes_off", {62'd0, ram_ce_n}, 64'd3);
        if (prev_done) chk("done_one_cycle", 64'd0, 64'd1);
        if (req_valid) chk("ready_b2b", {63'd0, req_ready}, 64'd1);
        pop_check();
      end
      prev_ce_low <= ~&ram_ce_n;
      prev_done   <= rsp_valid | wr_done;
    end
  end

  task automatic issue(input vec_t v);
    int n = 0;
    @(negedge clk);
    stim = v; req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_wdata = v.wdata; req_be = v.be;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("issue_accept", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || ram_ce_n != 2'b11) && n < 100) begin @(negedge clk); n++; end
    chk("drain_empty", sb_q.size(), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, a0, done_seen;
    vecs[0] = '{1'b0, 21'h012345, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 21'h100010, 32'hA5A50F0F, 4'h3, 32'h0};
    vecs[2] = '{1'b0, 21'h100010, 32'h0,        4'h0, EXP_V2};
    vecs[3] = '{1'b1, 21'h000021, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[4] = '{1'b0, 21'h000021, 32'h0,        4'h0, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 21'h100003, 32'h01234567, 4'hC, 32'h0};
    vecs[6] = '{1'b0, 21'h100003, 32'h0,        4'h0, EXP_V6};
    vecs[7] = '{1'b0, 21'h000002, 32'h0,        4'h0, 32'h0BADF00D};
    vecs[8] = '{1'b0, 21'h000021, 32'h0,        4'h0, 32'hCAFEF00D};
    stim = vecs[0];
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 21'h0;
    req_wdata = 32'h0; req_be = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_wr_done", {63'd0, wr_done}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rst_strobes", {58'd0, ram_ce_n, ram_oe_n, ram_we_n}, 64'h3F);
    chk("rst_be_n", {56'd0, ram_be_n}, 64'hFF);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) issue(vecs[i]);
    drain();

    // A request held valid through a whole read is accepted once, then again only in IDLE.
    @(negedge clk);
    stim = '{1'b0, 21'h012345, 32'h0, 4'h0, 32'hDEADBEEF};
    req_valid = 1'b1; req_we = 1'b0; req_addr = 21'h012345;
    a0 = acc_count;
    @(posedge clk); #1;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("held_rsp_seen", {63'd0, rsp_valid}, 64'd1);
    chk("held_one_accept", acc_count - a0, 64'd1);
    @(posedge clk); #1;
    chk("held_second_accept", acc_count - a0, 64'd2);
    req_valid = 1'b0;
    drain();

    // Reset during WR_PULSE: the write is aborted with no completion pulse.
    @(negedge clk);
    stim = '{1'b1, 21'h100005, 32'h55AA55AA, 4'hF, 32'h0};
    req_valid = 1'b1; req_we = 1'b1; req_addr = 21'h100005;
    req_wdata = 32'h55AA55AA; req_be = 4'hF;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (ram_we_n[1] && n < 20) begin @(negedge clk); n++; end
    chk("abort_in_pulse", {63'd0, ram_we_n[1]}, 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_we_n", {62'd0, ram_we_n}, 64'd3);
    chk("abort_ce_n", {62'd0, ram_ce_n}, 64'd3);
    @(posedge clk); #1 rst_n = 1'b1;
    done_seen = 0;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, req_ready}, 64'd1);
    repeat (8) begin
      @(negedge clk);
      if (wr_done || rsp_valid) done_seen++;
    end
    chk("abort_no_done", done_seen, 64'd0);

    issue('{1'b0, 21'h100010, 32'h0, 4'h0, 32'h11223344});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
